// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle RV32I datapath.
// Sequences every enable and mux select, and stalls on mem_ready.
module multicycle_ctrl #(
  parameter int OP_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ImmSrc,
  output logic            RegWrite,
  output logic            instr_done,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_IALU = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state, nxt;

  logic pcupdate, branch;
  logic irw, mw, rw, done, ill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= nxt;
  end

  always_comb begin
    nxt       = FETCH;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    done      = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcupdate  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_IALU:      nxt = EXECI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default: begin
            nxt  = FETCH;
            ill  = 1'b1;
            done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      nxt = MEMREAD;
        else if (op == OP_SW) nxt = MEMWRITE;
        else                  nxt = FETCH;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        nxt    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        done      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        done   = mem_ready;
        nxt    = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
        nxt      = ALUWB;
      end
      default: begin
        // unused codes select FETCH outputs and fall back to FETCH
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
    endcase
  end

  // strobes are masked by reset so nothing fires while it is held
  assign PCWrite    = reset_n & (pcupdate | (branch & zero));
  assign IRWrite    = reset_n & irw;
  assign MemWrite   = reset_n & mw;
  assign RegWrite   = reset_n & rw;
  assign instr_done = reset_n & done;
  assign illegal_op = reset_n & ill;

  always_comb begin
    unique case (1'b1)
      op == OP_SW:  ImmSrc = 2'b01;
      op == OP_BEQ: ImmSrc = 2'b10;
      op == OP_JAL: ImmSrc = 2'b11;
      default:      ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control words are queued
// at drive time and compared on the falling edge.
module tb_multicycle_ctrl;

  typedef enum {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } st_t;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IA   = 7'b0010011;
  localparam logic [6:0] BQ   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = RT;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic       instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [16:0] obs;

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  exp_t q[$];

  multicycle_ctrl #(.OP_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
                RegWrite, instr_done, illegal_op};

  task automatic chk(string tag, logic [16:0] got, logic [16:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(st_t s, logic [6:0] o,
                                        logic z, logic m);
    logic pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] rs, sa, sb, ao, im;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0; il = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (o)
      SW:      im = 2'b01;
      BQ:      im = 2'b10;
      JL:      im = 2'b11;
      default: im = 2'b00;
    endcase
    case (s)
      S_RST:    begin sb = 2'b10; rs = 2'b10; end
      S_FETCH:  begin sb = 2'b10; rs = 2'b10; irw = m; pcw = m; end
      S_DECODE: begin
        sa = 2'b01; sb = 2'b01;
        if (!(o inside {LW, SW, RT, IA, BQ, JL})) begin
          il = 1; dn = 1;
        end
      end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; dn = m; end
      S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      S_ALUWB:    begin rw = 1; dn = 1; end
      S_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; dn = 1; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, ao, im, rw, dn, il};
  endfunction

  task automatic cyc(st_t s, logic [6:0] o, logic z, logic m,
                     logic r = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n   = r;
    op        = o;
    zero      = z;
    mem_ready = m;
    ncyc++;
    e.tag = $sformatf("%s@%0d", s.name(), ncyc);
    e.v   = model(s, o, z, m);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, obs, e.v);
    end
  end

  initial begin
    // reset held for three cycles, then an R-type instruction
    cyc(S_RST, RT, 0, 1, 0);
    cyc(S_RST, RT, 0, 1, 0);
    cyc(S_RST, RT, 0, 1, 0);
    cyc(S_FETCH, RT, 0, 1);
    cyc(S_DECODE, RT, 0, 1);
    cyc(S_EXECR, RT, 0, 1);
    cyc(S_ALUWB, RT, 0, 1);
    // lw with two wait cycles in MEMREAD
    cyc(S_FETCH, LW, 0, 1);
    cyc(S_DECODE, LW, 0, 1);
    cyc(S_MEMADR, LW, 0, 1);
    cyc(S_MEMREAD, LW, 0, 0);
    cyc(S_MEMREAD, LW, 0, 0);
    cyc(S_MEMREAD, LW, 0, 1);
    cyc(S_MEMWB, LW, 0, 1);
    // sw with a wait in FETCH and in MEMWRITE
    cyc(S_FETCH, SW, 0, 0);
    cyc(S_FETCH, SW, 0, 1);
    cyc(S_DECODE, SW, 0, 1);
    cyc(S_MEMADR, SW, 0, 1);
    cyc(S_MEMWRITE, SW, 0, 0);
    cyc(S_MEMWRITE, SW, 0, 1);
    // beq taken then not taken
    cyc(S_FETCH, BQ, 1, 1);
    cyc(S_DECODE, BQ, 1, 1);
    cyc(S_BEQ, BQ, 1, 1);
    cyc(S_FETCH, BQ, 0, 1);
    cyc(S_DECODE, BQ, 0, 1);
    cyc(S_BEQ, BQ, 0, 1);
    // I-type ALU
    cyc(S_FETCH, IA, 0, 1);
    cyc(S_DECODE, IA, 0, 1);
    cyc(S_EXECI, IA, 1, 1);
    cyc(S_ALUWB, IA, 0, 1);
    // jal
    cyc(S_FETCH, JL, 0, 1);
    cyc(S_DECODE, JL, 0, 1);
    cyc(S_JAL, JL, 0, 1);
    cyc(S_ALUWB, JL, 0, 1);
    // illegal opcode returns straight to FETCH
    cyc(S_FETCH, BAD, 0, 1);
    cyc(S_DECODE, BAD, 0, 1);
    cyc(S_FETCH, RT, 0, 1);
    // op changes after decode must not alter sequencing
    cyc(S_DECODE, RT, 0, 1);
    cyc(S_EXECR, LW, 0, 1);
    cyc(S_ALUWB, SW, 0, 1);
    // asynchronous reset in the middle of a stalled store
    cyc(S_FETCH, SW, 0, 1);
    cyc(S_DECODE, SW, 0, 1);
    cyc(S_MEMADR, SW, 0, 1);
    cyc(S_MEMWRITE, SW, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("memwrite_async_drop", {16'd0, MemWrite}, 17'd0);
    chk("regwrite_async_drop", {16'd0, RegWrite}, 17'd0);
    cyc(S_RST, SW, 0, 0, 0);
    cyc(S_FETCH, RT, 0, 1);
    cyc(S_DECODE, RT, 0, 1);
    cyc(S_EXECR, RT, 0, 1);
    cyc(S_ALUWB, RT, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 17'(q.size()), 17'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one memory port, one ALU, and IR/OldPC/A/B/ALUOut/Data registers.
- Replaces the single-cycle decode path for the RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
- Drives every datapath enable and mux select each cycle.
- Stalls on a memory ready handshake and flags unsupported opcodes.

Parameters:
- OP_W, 7, opcode width.
- (None other. Encodings are fixed by this spec.)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- op  in  7  opcode from IR[6:0]; stable from DECODE onward
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load enable = PCUpdate | (Branch & zero)
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  loads IR and OldPC
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- ImmSrc  out  2  combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported op

Behaviour:
- State register: async clear to FETCH on reset_n = 0.
  - While reset is asserted: PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal_op = 0.
  - Selects take their FETCH values.
- Signals not listed for a state are 0.

States and outputs:
- FETCH: AdrSrc 0; ALUSrcA 00; ALUSrcB 10; ALUOp 00; ResultSrc 10.
  - IRWrite = PCUpdate = mem_ready.
  - mem_ready = 0: stay in FETCH. mem_ready = 1: go to DECODE.
- DECODE: ALUSrcA 01; ALUSrcB 01; ALUOp 00 (branch target into ALUOut).
  - lw or sw: MEMADR. R-type (0110011): EXECR. I-ALU (0010011): EXECI. beq: BEQ. jal: JAL.
  - Any other op: FETCH, with illegal_op = 1 and instr_done = 1.
- MEMADR: ALUSrcA 10; ALUSrcB 01; ALUOp 00.
  - lw (0000011): MEMREAD. sw (0100011): MEMWRITE.
- MEMREAD: AdrSrc 1; ResultSrc 00.
  - Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc 01; RegWrite 1; instr_done 1. Next: FETCH.
- MEMWRITE: AdrSrc 1; ResultSrc 00; MemWrite 1.
  - MemWrite stays high until the cycle mem_ready = 1.
  - In that cycle instr_done = 1 and the FSM goes to FETCH.
- EXECR: ALUSrcA 10; ALUSrcB 00; ALUOp 10. Next: ALUWB.
- EXECI: ALUSrcA 10; ALUSrcB 01; ALUOp 10. Next: ALUWB.
- ALUWB: ResultSrc 00; RegWrite 1; instr_done 1. Next: FETCH.
- BEQ: ALUSrcA 10; ALUSrcB 00; ALUOp 01; ResultSrc 00; Branch 1; instr_done 1. Next: FETCH.
  - PCWrite = zero.
- JAL: ALUSrcA 01; ALUSrcB 10; ALUOp 00 (PC+4 into ALUOut); ResultSrc 00 (ALUOut = target to PC); PCUpdate 1. Next: ALUWB.

Latency, with mem_ready tied to 1:
- lw 5 cycles; sw 4; R-type, I-ALU, jal 4; beq 3; illegal 2.
- Each memory wait cycle adds 1.

Boundary conditions:
- instr_done and illegal_op are combinational from state and inputs, never registered.
- op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Reset asserted mid-instruction: immediate return to FETCH. No partial MemWrite or RegWrite occurs after the reset edge.
- Encoding: state uses 4 bits. Unused codes recover to FETCH on the next clock.

Test Plan:
- Reset held low 3 cycles then released, mem_ready = 1, op = 0110011:
  - During reset: all enables 0.
  - Sequence FETCH, DECODE, EXECR, ALUWB.
  - RegWrite = 1 and instr_done = 1 only in cycle 4.
  - ALUOp = 10 in cycle 3.
- lw (op 0000011), mem_ready low for 2 cycles in MEMREAD:
  - Sequence FETCH, DECODE, MEMADR, MEMREAD ×3, MEMWB (7 cycles).
  - AdrSrc = 1 throughout MEMREAD.
  - RegWrite with ResultSrc = 01 in MEMWB.
- sw (op 0100011), mem_ready = 0 for 1 cycle in FETCH and 1 in MEMWRITE:
  - IRWrite = 0 then 1 in FETCH.
  - MemWrite high for 2 cycles.
  - instr_done pulses only with mem_ready = 1. Total 6 cycles.
- beq (op 1100011), once with zero = 1 and once with zero = 0:
  - BEQ state gives PCWrite = 1 and 0 respectively.
  - ALUOp = 01. ImmSrc = 10 throughout.
- jal (op 1101111):
  - PCWrite = 1 in FETCH and in JAL.
  - ALUWB follows with RegWrite = 1. ImmSrc = 11.
- op = 1111111 (illegal):
  - DECODE asserts illegal_op = 1 and instr_done = 1, then returns to FETCH.
- reset_n dropped asynchronously mid-MEMWRITE (between edges):
  - MemWrite falls immediately.
  - The FSM is in FETCH after release.
